ring_decoder: RTL and testbench
===============================

Name: ring_decoder

Overview:
- Receive-side companion to the one-hot ring counter.
- Samples the ring counter's parallel output each enabled cycle and converts the one-hot pattern to a binary position index.
- Checks that each new sample is the correct single-step rotation of the previous one, runs a lock state machine, counts completed laps and flags sequence errors.
- Sits next to the ring counter as its monitor/consumer in the same clock domain.

Parameters:
- WIDTH, 4, ring width in bits; must be a power of two, at least 2.
- IDXW, 2, index width; equals log2(WIDTH).
- LOCK_CNT, 2, consecutive correct rotations needed to declare lock; 1 to 15.
- LAP_W, 8, lap counter width.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- en  input  1  sample strobe; ring_in is evaluated only when en=1.
- ring_in  input  WIDTH  ring counter output.
- dir  input  1  expected rotation. 0: rotate right, e.g. 1000->0100->0010->0001->1000. 1: rotate left.
- lap_clr  input  1  synchronous clear of lap_cnt.
- idx  output  IDXW  bit position of the set bit in the last valid one-hot sample (bit 0 = LSB).
- idx_valid  output  1  last enabled sample was one-hot.
- locked  output  1  state machine is in LOCKED.
- err  output  1  one-cycle pulse on loss of lock.
- lap_cnt  output  LAP_W  completed laps while locked.
- err_cnt  output  8  number of lock losses; saturates at 255.

Behaviour:
- Reset (asynchronous, reset=0):
  - state=HUNT, prev=0, good=0.
  - idx=0, idx_valid=0, locked=0, err=0, lap_cnt=0, err_cnt=0.
- Latency: all outputs are registered and reflect the sample taken at the previous rising edge where en=1.
- One-hot test: exactly one bit of ring_in is set. All-zero and multi-bit patterns are invalid.
- exp = prev rotated by one position in the direction given by dir, as sampled in the same cycle.
- en=0:
  - state, prev, good, idx and counters hold.
  - idx_valid holds.
  - err is forced to 0.
- idx update (en=1):
  - One-hot sample: idx = position of the set bit, idx_valid=1.
  - Not one-hot: idx holds, idx_valid=0.
- States (transitions only when en=1):
  - HUNT:
    - One-hot: prev=ring_in, good=0, go to TRACK.
    - Otherwise stay in HUNT.
  - TRACK:
    - ring_in==exp: prev=ring_in, good+1. When the incremented good reaches LOCK_CNT, go to LOCKED.
    - One-hot but !=exp: prev=ring_in, good=0, stay in TRACK.
    - Not one-hot: go to HUNT.
    - No err in TRACK.
  - LOCKED:
    - ring_in==exp: prev=ring_in, stay.
    - Any mismatch (a stalled pattern, i.e. same as prev, counts as a mismatch): err=1 for one cycle, err_cnt increments (saturating at 255).
      - One-hot mismatch: go to TRACK with prev=ring_in, good=0.
      - Not one-hot: go to HUNT.
- locked = (state==LOCKED), registered.
- Lap counting:
  - Start position is bit WIDTH-1 for dir=0 and bit 0 for dir=1.
  - In LOCKED, a correct rotation landing on the start position increments lap_cnt, wrapping modulo 2^LAP_W.
  - The sample that completes lock does not count as a lap.
- lap_clr: lap_cnt=0 on the next edge and takes priority over a simultaneous increment. err_cnt is cleared only by reset.
- dir change while LOCKED: the next sample is checked against the new dir; a mismatch loses lock normally.
- Reset asserted mid-operation: immediate return to the reset values, independent of clk.

Test Plan:
- Reset release; en=1, dir=0, ring_in sequence 1000, 0100, 0010 -> idx 3, 2, 1; locked=1 one cycle after the 0010 sample; err=0 throughout.
- Locked, 8 full right rotations starting at 0001 -> lap_cnt=8. Assert lap_clr together with an increment -> lap_cnt=0.
- Locked, feed 0100 then 0001 (skip) -> err pulses for exactly one cycle, err_cnt=1, locked=0; the state machine relocks after LOCK_CNT further correct steps.
- Feed 0110 and 0000 -> idx_valid=0, idx holds its previous value; from LOCKED this gives err=1 and HUNT.
- dir=1, sequence 0001, 0010, 0100, 1000, 0001 -> locked; lap_cnt increments on the 0001. Holding en=0 for 5 cycles between steps changes nothing.
- Drop reset asynchronously between edges while locked -> all outputs zero immediately. 300 forced errors -> err_cnt=255.

Source files
------------

// File: rtl/ring_decoder.sv
// Monitors a one-hot ring counter: decodes position, tracks rotation lock, counts laps and lock losses.
// All outputs registered, one cycle after the enabled sample; no backpressure (en is a plain sample strobe).
module ring_decoder #(
  parameter int WIDTH    = 4,
  parameter int IDXW     = 2,
  parameter int LOCK_CNT = 2,
  parameter int LAP_W    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] ring_in,
  input  logic             dir,
  input  logic             lap_clr,
  output logic [IDXW-1:0]  idx,
  output logic             idx_valid,
  output logic             locked,
  output logic             err,
  output logic [LAP_W-1:0] lap_cnt,
  output logic [7:0]       err_cnt
);

  typedef enum logic [1:0] {HUNT, TRACK, LOCKED} state_t;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_t           state_q;
  logic [WIDTH-1:0] prev_q;
  logic [3:0]       good_q;
  logic [IDXW-1:0]  idx_q;
  logic             idx_valid_q;
  logic             locked_q;
  logic             err_q;
  logic [LAP_W-1:0] lap_q;
  logic [7:0]       err_cnt_q;

  logic             onehot;
  logic [IDXW-1:0]  oh_idx;
  logic [WIDTH-1:0] exp_pat;
  logic [WIDTH-1:0] start_pat;
  logic             match;
  logic             lap_hit;
  logic [3:0]       good_inc;

  always_comb begin
    onehot = (ring_in != '0) && ((ring_in & (ring_in - ONE)) == '0);
    oh_idx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (ring_in[i]) oh_idx = IDXW'(i);
    end
    // dir=0 moves the set bit towards the LSB, dir=1 towards the MSB
    exp_pat   = dir ? {prev_q[WIDTH-2:0], prev_q[WIDTH-1]}
                    : {prev_q[0], prev_q[WIDTH-1:1]};
    start_pat = dir ? ONE : (ONE << (WIDTH-1));
    match     = onehot && (ring_in == exp_pat);
    lap_hit   = (state_q == LOCKED) && match && (ring_in == start_pat);
    good_inc  = good_q + 4'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= HUNT;
      prev_q      <= '0;
      good_q      <= '0;
      idx_q       <= '0;
      idx_valid_q <= 1'b0;
      locked_q    <= 1'b0;
      err_q       <= 1'b0;
      lap_q       <= '0;
      err_cnt_q   <= '0;
    end else begin
      err_q <= 1'b0;

      if (lap_clr)            lap_q <= '0;
      else if (en && lap_hit) lap_q <= lap_q + 1'b1;

      if (en) begin
        if (onehot) begin
          idx_q       <= oh_idx;
          idx_valid_q <= 1'b1;
        end else begin
          idx_valid_q <= 1'b0;
        end

        case (state_q)
          HUNT: begin
            if (onehot) begin
              prev_q  <= ring_in;
              good_q  <= '0;
              state_q <= TRACK;
            end
          end
          TRACK: begin
            if (!onehot) begin
              state_q <= HUNT;
            end else if (match) begin
              prev_q <= ring_in;
              good_q <= good_inc;
              if (good_inc == 4'(LOCK_CNT)) begin
                state_q  <= LOCKED;
                locked_q <= 1'b1;
              end
            end else begin
              prev_q <= ring_in;
              good_q <= '0;
            end
          end
          LOCKED: begin
            if (match) begin
              prev_q <= ring_in;
            end else begin
              err_q    <= 1'b1;
              locked_q <= 1'b0;
              if (err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
              if (onehot) begin
                state_q <= TRACK;
                prev_q  <= ring_in;
                good_q  <= '0;
              end else begin
                state_q <= HUNT;
              end
            end
          end
          default: state_q <= HUNT;
        endcase
      end
    end
  end

  assign idx       = idx_q;
  assign idx_valid = idx_valid_q;
  assign locked    = locked_q;
  assign err       = err_q;
  assign lap_cnt   = lap_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_ring_decoder.sv
// Directed bench for ring_decoder (WIDTH=4, LOCK_CNT=2) with hand-computed expectations.
module tb_ring_decoder;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       en = 1'b0;
  logic [3:0] ring_in = 4'b0000;
  logic       dir = 1'b0;
  logic       lap_clr = 1'b0;
  logic [1:0] idx;
  logic       idx_valid;
  logic       locked;
  logic       err;
  logic [7:0] lap_cnt;
  logic [7:0] err_cnt;

  int errors = 0;
  int checks = 0;

  ring_decoder #(.WIDTH(4), .IDXW(2), .LOCK_CNT(2), .LAP_W(8)) dut (
    .clk(clk), .reset(reset), .en(en), .ring_in(ring_in), .dir(dir),
    .lap_clr(lap_clr), .idx(idx), .idx_valid(idx_valid), .locked(locked),
    .err(err), .lap_cnt(lap_cnt), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask

  // Present one enabled sample, then observe just after the capturing edge
  task automatic smp(input logic [3:0] r);
    ring_in = r;
    en = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    en = 1'b0;
    ring_in = 4'b1111;
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] rotr(input logic [3:0] v);
    return {v[0], v[3:1]};
  endfunction

  logic [3:0] p;

  initial begin
    #2;
    chk("rst_idx", idx, 0);
    chk("rst_vld", idx_valid, 0);
    chk("rst_locked", locked, 0);
    chk("rst_err", err, 0);
    chk("rst_lap", lap_cnt, 0);
    chk("rst_errcnt", err_cnt, 0);

    @(negedge clk);
    reset = 1'b1;
    dir = 1'b0;

    smp(4'b1000);
    chk("s1_idx", idx, 3); chk("s1_vld", idx_valid, 1); chk("s1_locked", locked, 0); chk("s1_err", err, 0);
    smp(4'b0100);
    chk("s2_idx", idx, 2); chk("s2_locked", locked, 0); chk("s2_err", err, 0);
    smp(4'b0010);
    chk("s3_idx", idx, 1); chk("s3_locked", locked, 1); chk("s3_err", err, 0);

    for (int k = 0; k < 8; k++) begin
      smp(4'b0001);
      smp(4'b1000);
      chk("lap_step", lap_cnt, k + 1);
      smp(4'b0100);
      smp(4'b0010);
    end
    chk("lap8", lap_cnt, 8);
    chk("lap8_locked", locked, 1);
    chk("lap8_err", err, 0);

    smp(4'b0001);
    lap_clr = 1'b1;
    smp(4'b1000);
    lap_clr = 1'b0;
    chk("lapclr_prio", lap_cnt, 0);
    chk("lapclr_locked", locked, 1);

    smp(4'b0100);
    smp(4'b0001);
    chk("skip_err", err, 1); chk("skip_errcnt", err_cnt, 1);
    chk("skip_locked", locked, 0); chk("skip_idx", idx, 0);
    smp(4'b1000);
    chk("skip_err_1cyc", err, 0); chk("relock1_locked", locked, 0);
    smp(4'b0100);
    chk("relock2_locked", locked, 1); chk("relock_errcnt", err_cnt, 1);

    smp(4'b0110);
    chk("multi_vld", idx_valid, 0); chk("multi_idx", idx, 2);
    chk("multi_err", err, 1); chk("multi_locked", locked, 0); chk("multi_errcnt", err_cnt, 2);
    smp(4'b0000);
    chk("zero_vld", idx_valid, 0); chk("zero_idx", idx, 2); chk("zero_err_hunt", err, 0);

    dir = 1'b1;
    smp(4'b0001);
    chk("l1_idx", idx, 0); chk("l1_vld", idx_valid, 1); chk("l1_locked", locked, 0);
    idle(5);
    chk("idle_idx", idx, 0); chk("idle_vld", idx_valid, 1); chk("idle_locked", locked, 0);
    smp(4'b0010);
    chk("l2_locked", locked, 0);
    smp(4'b0100);
    chk("l3_locked", locked, 1); chk("l3_lap", lap_cnt, 0);
    idle(5);
    chk("idle2_locked", locked, 1); chk("idle2_idx", idx, 2); chk("idle2_err", err, 0);
    smp(4'b1000);
    chk("l4_idx", idx, 3); chk("l4_lap", lap_cnt, 0);
    smp(4'b0001);
    chk("l5_lap", lap_cnt, 1); chk("l5_locked", locked, 1); chk("l5_err", err, 0);

    smp(4'b0001);
    chk("stall_err", err, 1); chk("stall_errcnt", err_cnt, 3);
    idle(1);
    chk("en0_err_forced", err, 0); chk("en0_errcnt", err_cnt, 3);

    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    chk("arst_idx", idx, 0); chk("arst_vld", idx_valid, 0); chk("arst_locked", locked, 0);
    chk("arst_lap", lap_cnt, 0); chk("arst_errcnt", err_cnt, 0); chk("arst_err", err, 0);
    @(negedge clk);
    reset = 1'b1;

    dir = 1'b0;
    smp(4'b1000); smp(4'b0100); smp(4'b0010);
    chk("sat_prelock", locked, 1);
    p = 4'b0010;
    for (int k = 0; k < 300; k++) begin
      smp(p);
      p = rotr(p); smp(p);
      p = rotr(p); smp(p);
    end
    chk("sat_errcnt", err_cnt, 255);
    chk("sat_relocked", locked, 1);
    smp(p);
    chk("sat_err_pulse", err, 1);
    chk("sat_hold", err_cnt, 255);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
